// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-addressed data memory with combinational read
// and one-cycle word write; RMW for SB/SH. Optional macro: DMEM_LSU_MISALIGN_TRAP_EN.
module dmem_lsu #(
   parameter int unsigned INT_DMEM_SIZE = 1024
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_WE,
   input  logic [2:0]  REQ_FUNCT3,
   input  logic [31:0] REQ_ADDR,
   input  logic [31:0] REQ_WDATA,
   output logic        RSP_VALID,
   output logic [31:0] RSP_RDATA,
   output logic        RSP_ERR,
   output logic        AWVALID,
   output logic [31:0] AWADDR,
   output logic [31:0] WDATA,
   output logic [31:0] ARADDR,
   input  logic [31:0] RDATA
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

   state_e      state_q, state_d;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        accept;
   logic        f3_legal;
   logic        misal;
   logic        misal_err;
   logic        range_err;
   logic        req_err;
   logic [31:0] addr_al;
   logic [31:0] word_idx;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;
   logic [31:0] merged;

   assign accept = REQ_VALID & REQ_READY;

   always_comb begin : req_decode
      f3_legal  = REQ_WE ? (REQ_FUNCT3 inside {3'b000, 3'b001, 3'b010})
                         : (REQ_FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      misal     = 1'b0;
      addr_al   = REQ_ADDR;
      case (REQ_FUNCT3[1:0])
         2'b01:   misal = REQ_ADDR[0];
         2'b10:   misal = (REQ_ADDR[1:0] != 2'b00);
         default: misal = 1'b0;
      endcase
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
      misal_err = misal;
`else
      // Without the trap, offset bits are forced to natural alignment before the range check.
      misal_err = 1'b0;
      case (REQ_FUNCT3[1:0])
         2'b01:   addr_al[0]   = 1'b0;
         2'b10:   addr_al[1:0] = 2'b00;
         default: addr_al      = REQ_ADDR;
      endcase
`endif
      range_err = ({2'b00, addr_al[31:2]} >= 32'(INT_DMEM_SIZE));
      req_err   = ~f3_legal | misal_err | range_err;
   end

   assign word_idx = {2'b00, addr_q[31:2]};

   always_comb begin : lane_logic
      byte_sel = RDATA[{addr_q[1:0], 3'b000} +: 8];
      half_sel = RDATA[{addr_q[1], 4'b0000} +: 16];
      case (f3_q)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_ext = {24'h000000, byte_sel};
         3'b101:  load_ext = {16'h0000, half_sel};
         default: load_ext = RDATA;
      endcase
      merged = RDATA;
      if (f3_q[1:0] == 2'b00) begin
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin : state_reg
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (req_err) begin
                  state_d = S_RESP;
               end else if (REQ_WE && (REQ_FUNCT3 == 3'b010)) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ:  state_d = we_q ? S_WRITE : S_RESP;
         S_WRITE: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
      endcase
   end

   always_comb begin : outputs
      REQ_READY = (state_q == S_IDLE) & ~RST;
      AWVALID   = (state_q == S_WRITE) & ~RST;
      RSP_VALID = (state_q == S_RESP);
      ARADDR    = (state_q == S_IDLE) ? '0 : word_idx;
      AWADDR    = (state_q == S_IDLE) ? '0 : word_idx;
   end

   // Response registers change only on entry to RESP so they hold between responses.
   always_ff @(posedge CLK or posedge RST) begin : datapath
      if (RST) begin
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  we_q   <= REQ_WE;
                  f3_q   <= REQ_FUNCT3;
                  addr_q <= addr_al;
                  if (REQ_WE && !req_err) begin
                     wdata_q <= REQ_WDATA;
                  end
                  if (req_err) begin
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                  end
               end
            end
            S_READ: begin
               if (we_q) begin
                  wdata_q <= merged;
               end else begin
                  rdata_q <= load_ext;
                  err_q   <= 1'b0;
               end
            end
            S_WRITE: begin
               rdata_q <= '0;
               err_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign WDATA     = wdata_q;
   assign RSP_RDATA = rdata_q;
   assign RSP_ERR   = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized self-checking bench for dmem_lsu against a byte-level reference model.
// Honours DMEM_LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_dmem_lsu;
   localparam int unsigned DEPTH = 1024;

   logic        CLK, RST;
   logic        REQ_VALID, REQ_READY, REQ_WE;
   logic [2:0]  REQ_FUNCT3;
   logic [31:0] REQ_ADDR, REQ_WDATA;
   logic        RSP_VALID, RSP_ERR, AWVALID;
   logic [31:0] RSP_RDATA, AWADDR, WDATA, ARADDR, RDATA;

   dmem_lsu #(.INT_DMEM_SIZE(DEPTH)) dut (
      .CLK(CLK), .RST(RST),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
      .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
      .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
      .AWVALID(AWVALID), .AWADDR(AWADDR), .WDATA(WDATA),
      .ARADDR(ARADDR), .RDATA(RDATA)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Memory the DUT drives; preload port lets the bench seed it while the LSU is idle.
   logic [31:0] dmem [DEPTH];
   logic        pl_we;
   logic [9:0]  pl_idx;
   logic [31:0] pl_dat;
   always @(posedge CLK) begin
      if (pl_we) dmem[pl_idx] <= pl_dat;
      else if (AWVALID && AWADDR < DEPTH) dmem[AWADDR[9:0]] <= WDATA;
   end
   assign RDATA = (ARADDR < DEPTH) ? dmem[ARADDR[9:0]] : 32'hDEADBEEF;

   logic [31:0] ref_mem [DEPTH];
   int n_chk, n_err;
   logic [31:0] last_rd, last_wd;
   logic        last_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic pre_word(input int unsigned idx, input logic [31:0] val);
      pl_we = 1'b1; pl_idx = 10'(idx); pl_dat = val;
      @(negedge CLK);
      pl_we = 1'b0;
      ref_mem[idx] = val;
   endtask

   task automatic ref_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic err, output logic [31:0] rd,
                            output logic [31:0] idx, output logic [31:0] nw);
      logic        legal;
      int          sz, off;
      logic [31:0] a, word;
      longint      v;
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      err = !legal; rd = '0; nw = '0; idx = '0;
      if (!legal) return;
      sz = 1 << f3[1:0];
      a  = addr;
      if (a % sz != 0) begin
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
         err = 1'b1;
`else
         a = a - (a % sz);
`endif
      end
      idx = a / 4;
      if (idx >= DEPTH) err = 1'b1;
      if (err) return;
      off  = int'(a % 4);
      word = ref_mem[idx[9:0]];
      if (!we) begin
         v = (longint'(word) >> (off * 8)) & ((longint'(1) << (8 * sz)) - 1);
         if (f3 < 3'd4 && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
         rd = v[31:0];
      end else begin
         nw = word;
         for (int i = 0; i < sz; i++) nw[(off + i) * 8 +: 8] = wd[i * 8 +: 8];
      end
   endtask

   // Called at a negedge; returns at a negedge with the LSU idle again.
   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
      logic        e_err;
      logic [31:0] e_rd, e_idx, e_nw;
      int          w, e_rsp, e_aw, rsp_at, rsp_cnt, aw_at, aw_cnt;
      logic [31:0] g_awaddr, g_wdata;
      ref_model(we, f3, addr, wd, e_err, e_rd, e_idx, e_nw);
      if (e_err) begin e_rsp = 1; e_aw = 0; end
      else if (!we) begin e_rsp = 2; e_aw = 0; end
      else if (f3 == 3'd2) begin e_rsp = 2; e_aw = 1; end
      else begin e_rsp = 3; e_aw = 2; end
      w = 0;
      while (!REQ_READY && w < 10) begin @(negedge CLK); w++; end
      if (!REQ_READY) begin
         check("ready_timeout", 32'(REQ_READY), 32'd1);
         return;
      end
      REQ_VALID = 1'b1; REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = addr; REQ_WDATA = wd;
      @(posedge CLK);
      rsp_at = 0; rsp_cnt = 0; aw_at = 0; aw_cnt = 0; g_awaddr = '0; g_wdata = '0;
      for (int n = 1; n <= 5; n++) begin
         @(negedge CLK);
         if (n == 1) begin
            REQ_VALID = 1'b0;
            check("ready_busy", 32'(REQ_READY), 32'd0);
         end
         if (RSP_VALID) begin
            rsp_cnt++; rsp_at = n; last_rd = RSP_RDATA; last_err = RSP_ERR;
         end
         if (AWVALID) begin
            aw_cnt++; aw_at = n; g_awaddr = AWADDR; g_wdata = WDATA;
         end
      end
      check("rsp_cycle", 32'(rsp_at), 32'(e_rsp));
      check("rsp_count", 32'(rsp_cnt), 32'd1);
      check("aw_count", 32'(aw_cnt), (e_aw != 0) ? 32'd1 : 32'd0);
      check("rsp_err", 32'(last_err), 32'(e_err));
      check("rsp_rdata", last_rd, e_rd);
      if (e_aw != 0) begin
         check("aw_cycle", 32'(aw_at), 32'(e_aw));
         check("awaddr", g_awaddr, e_idx);
         check("wdata", g_wdata, e_nw);
         ref_mem[e_idx[9:0]] = e_nw;
      end
      last_wd = g_wdata;
   endtask

   task automatic rand_req();
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
         case ($urandom_range(0, 4))
            0: f3 = 3'd0;
            1: f3 = 3'd1;
            2: f3 = 3'd2;
            3: f3 = 3'd4;
            default: f3 = 3'd5;
         endcase
      end
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      else addr = 32'($urandom_range(0, 4 * DEPTH + 31));
      run_req(we, f3, addr, $urandom);
   endtask

   int last_t, ready_cnt;

   initial begin
      n_chk = 0; n_err = 0;
      RST = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_FUNCT3 = '0;
      REQ_ADDR = '0; REQ_WDATA = '0; pl_we = 1'b0; pl_idx = '0; pl_dat = '0;
      @(negedge CLK);
      for (int unsigned i = 0; i < DEPTH; i++) pre_word(i, $urandom);

      check("rst_ready", 32'(REQ_READY), 32'd0);
      check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
      check("rst_rsp_err", 32'(RSP_ERR), 32'd0);
      check("rst_rsp_rdata", RSP_RDATA, 32'd0);
      check("rst_awvalid", 32'(AWVALID), 32'd0);
      check("rst_awaddr", AWADDR, 32'd0);
      check("rst_wdata", WDATA, 32'd0);
      check("rst_araddr", ARADDR, 32'd0);
      RST = 1'b0;
      #1 check("ready_after_rst", 32'(REQ_READY), 32'd1);
      @(negedge CLK);

      pre_word(5, 32'h8899AABB);
      run_req(1'b0, 3'd0, 32'h16, '0);
      check("lb_const", last_rd, 32'hFFFFFF99);
      run_req(1'b0, 3'd4, 32'h16, '0);
      check("lbu_const", last_rd, 32'h00000099);
      run_req(1'b0, 3'd5, 32'h14, '0);
      check("lhu_const", last_rd, 32'h0000AABB);

      pre_word(5, 32'h11223344);
      run_req(1'b1, 3'd0, 32'h15, 32'hDEADBEEF);
      check("sb_const", last_wd, 32'h1122EF44);
      pre_word(6, 32'h0);
      run_req(1'b1, 3'd1, 32'h1A, 32'h0000CAFE);
      check("sh_const", last_wd, 32'hCAFE0000);
      run_req(1'b0, 3'd2, 32'h18, '0);
      check("lw_after_sh", last_rd, 32'hCAFE0000);

      run_req(1'b0, 3'd2, 32'h1002, '0);
      check("lw_oob_err", 32'(last_err), 32'd1);
      run_req(1'b0, 3'd2, 32'h102, '0);
      run_req(1'b0, 3'd3, 32'h20, '0);
      check("illegal_f3_err", 32'(last_err), 32'd1);
      run_req(1'b1, 3'd3, 32'h20, 32'h1);
      run_req(1'b1, 3'd2, 4 * DEPTH - 4, 32'hA5A55A5A);
      run_req(1'b1, 3'd2, 4 * DEPTH, 32'hA5A55A5A);

      // Back-to-back LW with REQ_VALID held high.
      REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_FUNCT3 = 3'd2; REQ_ADDR = 32'h18;
      last_t = -1; ready_cnt = 0;
      for (int t = 0; t < 12; t++) begin
         if (REQ_READY) begin
            if (last_t >= 0) check("b2b_gap", 32'(t - last_t), 32'd3);
            last_t = t; ready_cnt++;
         end
         if (RSP_VALID) check("b2b_data", RSP_RDATA, ref_mem[6]);
         @(negedge CLK);
      end
      check("b2b_accepts", 32'(ready_cnt), 32'd4);
      REQ_VALID = 1'b0;
      repeat (4) @(negedge CLK);

      // Reset during the WRITE cycle of an SW.
      REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_FUNCT3 = 3'd2; REQ_ADDR = 32'hC0;
      REQ_WDATA = 32'h12345678;
      @(posedge CLK);
      @(negedge CLK);
      REQ_VALID = 1'b0;
      check("abort_aw_before", 32'(AWVALID), 32'd1);
      RST = 1'b1;
      #1;
      check("abort_aw_drop", 32'(AWVALID), 32'd0);
      check("abort_ready_rst", 32'(REQ_READY), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      for (int n = 0; n < 3; n++) begin
         #1 check("abort_no_rsp", 32'(RSP_VALID), 32'd0);
         check("abort_ready", 32'(REQ_READY), 32'd1);
         @(negedge CLK);
      end
      check("abort_mem", dmem[48], ref_mem[48]);

      for (int k = 0; k < 300; k++) rand_req();

      for (int unsigned i = 0; i < DEPTH; i++) check("mem_final", dmem[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit for the RV32I core: the initiator side of the data-memory port. It accepts one load or store request at a time from the execute stage and drives the word-addressed data memory. That memory has a one-cycle word write (AWVALID/AWADDR/WDATA), no byte strobes, and a combinational read (ARADDR→RDATA). The block converts byte addresses to word indices, performs read-modify-write for SB/SH, and sign- or zero-extends load data. It returns a single-cycle response to the core.

## Interface
- INT_DMEM_SIZE, 1024, memory depth in 32-bit words; word indices ≥ this are out of range
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- REQ_VALID  in  1  core request valid
- REQ_READY  out  1  LSU can accept a request
- REQ_WE  in  1  1 = store, 0 = load
- REQ_FUNCT3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- REQ_ADDR  in  32  byte address
- REQ_WDATA  in  32  store data, LSB-aligned
- RSP_VALID  out  1  one-cycle completion pulse
- RSP_RDATA  out  32  extended load data (0 for stores/errors)
- RSP_ERR  out  1  request rejected, no memory access performed
- AWVALID  out  1  memory write enable
- AWADDR  out  32  memory write word index
- WDATA  out  32  memory write data
- ARADDR  out  32  memory read word index
- RDATA  in  32  memory read data (combinational from ARADDR)

## Operation
- States: IDLE, READ, WRITE, RESP. Reset → IDLE.
- REQ_READY = (state==IDLE) & ~RST. A request is accepted on an edge with REQ_VALID & REQ_READY; WE, funct3, addr and wdata are registered.
- Word index = {2'b00, addr[31:2]}; driven on ARADDR/AWADDR from the registered address in all non-IDLE states.
- Error check at accept: illegal funct3 (load 011/110/111, store ≥011), misaligned (H with addr[0]=1, W with addr[1:0]≠0; see Configuration), or word index ≥ INT_DMEM_SIZE → next state RESP with RSP_ERR=1, no AWVALID.
- Load: IDLE→READ→RESP. In READ, RDATA is sampled and the lane is selected: byte = addr[1:0], half = addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. The result is registered into RSP_RDATA.
- SW: IDLE→WRITE→RESP. WDATA = REQ_WDATA.
- SB/SH: IDLE→READ→WRITE→RESP. In READ, the byte/half of RDATA is merged with wdata[7:0]/[15:0] at the selected lane and registered into WDATA.
- WRITE: AWVALID=1 for exactly one cycle; the memory writes on the closing edge.
- RESP: RSP_VALID=1 for one cycle with RSP_RDATA/RSP_ERR, then →IDLE. No response back-pressure.
- RSP_RDATA and RSP_ERR hold their values until the next RESP; they are only meaningful with RSP_VALID.
- RST asserted in any state: immediately →IDLE, and AWVALID drops asynchronously, so no write occurs on that edge. There is no response for the aborted request.

## Timing
- Accept at edge k. Load response: RSP_VALID high in cycle k+2 (edge k+1 to k+2). SW: AWVALID in cycle k+1, RSP_VALID in cycle k+2. SB/SH: READ in cycle k+1, AWVALID in k+2, RSP_VALID in k+3. Error: RSP_VALID in cycle k+1.
- Earliest next accept is the edge after the RESP cycle. Throughput is one request per 3 cycles (loads/SW) or 4 cycles (SB/SH).
- Reset values: REQ_READY 0 (1 once RST deasserts), RSP_VALID 0, RSP_ERR 0, RSP_RDATA 0, AWVALID 0, AWADDR 0, WDATA 0, ARADDR 0.

## Configuration
- DMEM_LSU_MISALIGN_TRAP_EN defined: misaligned H/W accesses complete with RSP_ERR=1 and no memory access.
- Not defined: misalignment is not an error. The offset bits are forced to natural alignment (H: addr[0]→0; W: addr[1:0]→00) and the access proceeds normally. RSP_ERR is raised only for illegal funct3 or out-of-range index.

## Test plan
- Mem[5]=0x8899AABB. LB addr 0x16 → RSP_RDATA 0xFFFFFF99 at k+2. LBU addr 0x16 → 0x00000099. LHU 0x14 → 0x0000AABB.
- Mem[5]=0x11223344. SB wdata 0xDEADBEEF addr 0x15 → single AWVALID at k+2, AWADDR 5, WDATA 0x1122EF44. RSP_VALID at k+3.
- SH 0xCAFE to addr 0x1A over Mem[6]=0 → WDATA 0xCAFE0000. A following LW 0x18 returns 0xCAFE0000.
- With the macro, LW at 0x1002 → RSP_ERR=1 at k+1, AWVALID never high. Without the macro → reads Mem[0x400>>0]… index 0x400 ≥1024 → RSP_ERR=1. LW at 0x102 → returns Mem[0x40].
- REQ_FUNCT3=011 load → RSP_ERR=1, RSP_RDATA 0. REQ_VALID held high throughout → REQ_READY low except in IDLE. Successive accepts are exactly 3 cycles apart for back-to-back LW.
- Assert RST during the WRITE cycle of SW 0x12345678 → AWVALID falls immediately, Mem unchanged, RSP_VALID stays 0, REQ_READY=1 the cycle after RST deasserts.
